// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and fills the
// IF/ID register, honouring stall/flush and EX redirects (held across stalls).
//
// state      | meaning
// RUN        | no redirect pending; PC advances or redirects directly
// HOLD_REDIR | redirect accepted while stalled; target waits in pend_pc
module if_stage #(
    parameter int                  PC_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [31:0]         NOP      = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic [PC_WIDTH-1:0] im_pc,
    input  logic [31:0]         im_ins,
    output logic [31:0]         id_ins,
    output logic [PC_WIDTH-1:0] id_pc,
    output logic [PC_WIDTH-1:0] id_pc_plus4,
    output logic                id_valid,
    output logic [15:0]         fetch_count
);

    typedef enum logic {
        RUN        = 1'b0,
        HOLD_REDIR = 1'b1
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {{(PC_WIDTH-2){1'b1}}, 2'b00};

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] pc_reg, pc_nxt;
    logic [PC_WIDTH-1:0] pend_pc, pend_pc_nxt;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] redirect_target;
    logic                redir_taken;

    assign im_pc           = pc_reg;
    assign pc_plus4        = pc_reg + PC_STEP;
    assign redirect_target = redirect_pc & ALIGN_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            pc_reg  <= RESET_PC;
            pend_pc <= '0;
        end else begin
            state   <= state_nxt;
            pc_reg  <= pc_nxt;
            pend_pc <= pend_pc_nxt;
        end
    end

    // A fresh unstalled redirect beats both a pending one and sequential fetch.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_reg;
        pend_pc_nxt = pend_pc;
        redir_taken = 1'b0;
        if (redirect_valid && !stall) begin
            pc_nxt      = redirect_target;
            state_nxt   = RUN;
            redir_taken = 1'b1;
        end else if (redirect_valid) begin
            pend_pc_nxt = redirect_target;
            state_nxt   = HOLD_REDIR;
        end else if (!stall && state == HOLD_REDIR) begin
            pc_nxt      = pend_pc;
            state_nxt   = RUN;
            redir_taken = 1'b1;
        end else if (!stall) begin
            pc_nxt      = pc_plus4;
        end
    end

    // The word fetched in a redirect-taken cycle is wrong-path, so it is bubbled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ins      <= NOP;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            id_valid    <= 1'b0;
            fetch_count <= '0;
        end else if (flush || (!stall && redir_taken)) begin
            id_ins      <= NOP;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            id_valid    <= 1'b0;
        end else if (!stall) begin
            id_ins      <= im_ins;
            id_pc       <= pc_reg;
            id_pc_plus4 <= pc_plus4;
            id_valid    <= 1'b1;
            fetch_count <= fetch_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized traffic, each checked
// against a rule-level model of PC sequencing and IF/ID contents.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [9:0]  redirect_pc = '0;
    logic [9:0]  im_pc;
    logic [31:0] im_ins;
    logic [31:0] id_ins;
    logic [9:0]  id_pc;
    logic [9:0]  id_pc_plus4;
    logic        id_valid;
    logic [15:0] fetch_count;

    logic [31:0] mem [256];

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state (plain integers, byte addresses modulo 1024)
    int          m_pc, m_pend_pc, m_id_pc, m_id_p4, m_cnt;
    bit          m_pend_v, m_valid;
    logic [31:0] m_ins;

    if_stage #(.PC_WIDTH(10), .RESET_PC(10'h000), .NOP(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .im_pc(im_pc), .im_ins(im_ins), .id_ins(id_ins), .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4), .id_valid(id_valid), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    assign im_ins = mem[im_pc[9:2]];

    wire [78:0] dut_vec = {im_pc, id_ins, id_pc, id_pc_plus4, id_valid, fetch_count};

    function automatic logic [78:0] model_vec();
        return {10'(m_pc), m_ins, 10'(m_id_pc), 10'(m_id_p4), m_valid, 16'(m_cnt)};
    endfunction

    task automatic model_reset();
        m_pc = 0; m_pend_v = 0; m_pend_pc = 0;
        m_ins = 32'h0; m_id_pc = 0; m_id_p4 = 0; m_valid = 0; m_cnt = 0;
    endtask

    task automatic model_bubble();
        m_ins = 32'h0; m_id_pc = 0; m_id_p4 = 0; m_valid = 0;
    endtask

    task automatic model_edge(input bit s, input bit f, input bit rv, input int rpc);
        int  tgt;
        int  npc;
        bit  taken;
        tgt   = (rpc % 1024) / 4 * 4;
        npc   = m_pc;
        taken = 0;
        if (rv && !s) begin
            npc = tgt; m_pend_v = 0; taken = 1;
        end else if (rv) begin
            m_pend_pc = tgt; m_pend_v = 1;
        end else if (!s && m_pend_v) begin
            npc = m_pend_pc; m_pend_v = 0; taken = 1;
        end else if (!s) begin
            npc = (m_pc + 4) % 1024;
        end
        if (f || (!s && taken)) begin
            model_bubble();
        end else if (!s) begin
            m_ins   = mem[m_pc / 4];
            m_id_pc = m_pc;
            m_id_p4 = (m_pc + 4) % 1024;
            m_valid = 1;
            m_cnt   = (m_cnt + 1) % 65536;
        end
        m_pc = npc;
    endtask

    // Starts and ends at a falling edge; inputs held across one rising edge.
    task automatic cycle(input bit s, input bit f, input bit rv, input int rpc);
        stall = s; flush = f; redirect_valid = rv; redirect_pc = 10'(rpc);
        @(posedge clk);
        #1;
        model_edge(s, f, rv, rpc);
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 0; flush = 0; redirect_valid = 0; redirect_pc = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        do_reset();
        tests_run++;
        if (dut_vec !== model_vec() || im_pc !== 10'h000 || id_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0);
            tests_run++;
            if (dut_vec !== model_vec() || im_pc !== 10'((i + 1) * 4) || id_pc !== 10'(i * 4)) begin
                tests_failed++;
                $display("FAIL sequential[%0d]: got im_pc=%0d id_pc=%0d vec=%h expected vec=%h",
                         i, im_pc, id_pc, dut_vec, model_vec());
            end
        end
        tests_run++;
        if (fetch_count !== 16'd4) begin
            tests_failed++;
            $display("FAIL sequential_count: got %0d expected 4", fetch_count);
        end
    endtask

    task automatic test_wrap();
        int exp_pc [4] = '{1016, 1020, 0, 4};
        do_reset();
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 1016);
        tests_run++;
        if (im_pc !== 10'(exp_pc[0]) || dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL wrap[0]: got im_pc=%0d expected %0d", im_pc, exp_pc[0]);
        end
        for (int i = 1; i < 4; i++) begin
            cycle(0, 0, 0, 0);
            tests_run++;
            if (im_pc !== 10'(exp_pc[i]) || dut_vec !== model_vec()) begin
                tests_failed++;
                $display("FAIL wrap[%0d]: got im_pc=%0d vec=%h expected im_pc=%0d vec=%h",
                         i, im_pc, dut_vec, exp_pc[i], model_vec());
            end
            if (i == 2) begin
                tests_run++;
                if (id_pc !== 10'd1020 || id_pc_plus4 !== 10'd0) begin
                    tests_failed++;
                    $display("FAIL wrap_plus4: got id_pc=%0d plus4=%0d expected 1020 and 0",
                             id_pc, id_pc_plus4);
                end
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 'h41);
        tests_run++;
        if (im_pc !== 10'h40 || id_valid !== 1'b0 || id_ins !== 32'h0 || dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL redirect_bubble: got im_pc=%h valid=%b ins=%h expected 040 0 0",
                     im_pc, id_valid, id_ins);
        end
        cycle(0, 0, 0, 0);
        tests_run++;
        if (id_pc !== 10'h40 || id_valid !== 1'b1 || id_ins !== mem['h10] || dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL redirect_target: got id_pc=%h valid=%b expected 040 1", id_pc, id_valid);
        end
    endtask

    task automatic test_stall_redirect(input bit second);
        logic [9:0] held;
        int         target;
        do_reset();
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        held   = im_pc;
        target = second ? 'h90 : 'h80;
        cycle(1, 0, 1, 'h80);
        cycle(1, 0, second, 'h92);
        cycle(1, 0, 0, 0);
        tests_run++;
        if (im_pc !== held || dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL stall_hold(second=%0d): got im_pc=%h expected %h", second, im_pc, held);
        end
        cycle(0, 0, 0, 0);
        tests_run++;
        if (im_pc !== 10'(target) || id_valid !== 1'b0 || dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL stall_release(second=%0d): got im_pc=%h valid=%b expected %h 0",
                     second, im_pc, id_valid, target);
        end
        cycle(0, 0, 0, 0);
        tests_run++;
        if (id_pc !== 10'(target) || id_valid !== 1'b1 || dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL stall_target(second=%0d): got id_pc=%h valid=%b expected %h 1",
                     second, id_pc, id_valid, target);
        end
    endtask

    task automatic test_stall_flush();
        logic [9:0]  pc_before;
        logic [15:0] cnt_before;
        do_reset();
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        pc_before  = im_pc;
        cnt_before = fetch_count;
        cycle(1, 1, 0, 0);
        tests_run++;
        if (im_pc !== pc_before || id_valid !== 1'b0 || fetch_count !== cnt_before ||
            dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL stall_flush: got pc=%h valid=%b cnt=%0d expected pc=%h valid=0 cnt=%0d",
                     im_pc, id_valid, fetch_count, pc_before, cnt_before);
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        cycle(0, 0, 0, 0);
        cycle(1, 0, 1, 'h200);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (dut_vec !== model_vec()) begin
            tests_failed++;
            $display("FAIL async_reset: got %h expected %h", dut_vec, model_vec());
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            tests_run++;
            if (im_pc === 10'h200 || dut_vec !== model_vec()) begin
                tests_failed++;
                $display("FAIL reset_pending[%0d]: got %h expected %h", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_random();
        int errs = 0;
        bit s, f, rv;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            s  = ($urandom_range(0, 99) < 30);
            f  = ($urandom_range(0, 99) < 10);
            rv = ($urandom_range(0, 99) < 15);
            cycle(s, f, rv, int'($urandom_range(0, 1023)));
            tests_run++;
            if (dut_vec !== model_vec()) begin
                tests_failed++;
                if (errs < 5)
                    $display("FAIL random[%0d]: got %h expected %h", i, dut_vec, model_vec());
                errs++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        model_reset();
        test_reset();
        test_sequential();
        test_wrap();
        test_redirect();
        test_stall_redirect(1'b0);
        test_stall_redirect(1'b1);
        test_stall_flush();
        test_reset_pending();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
